regfile_2r1w: RTL and testbench

//  - CPU register file: 32 x 32-bit storage, one synchronous write port, two combinational read ports.
//  - Read side of the per-register enable-gated storage. Feeds ALU operands A/B; the write-back stage drives the write port.
//  - Register 0 is hardwired to zero (MIPS-style $zero).

---
 rtl/regfile_2r1w_pkg.sv | 10 +
 rtl/decoder_1to32.sv | 23 ++
 rtl/mux32to1by32.sv | 17 +
 rtl/register32.sv | 25 ++
 rtl/regfile_2r1w.sv | 56 +++++
 tb/tb_regfile_2r1w.sv | 131 +++++++++++++
 6 files changed

// File: rtl/regfile_2r1w_pkg.sv
// Shared constants for the 32 x 32-bit two-read / one-write register file.
package regfile_2r1w_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/decoder_1to32.sv
// Write-address decoder: one-hot of address, gated by enable.
// Register 0 has no storage cell, so only outputs 1..COUNT-1 exist.
module decoder_1to32
  import regfile_2r1w_pkg::*;
#(
  parameter int COUNT  = REG_COUNT,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              enable,
  input  logic [ADDR_W-1:0] address,
  output logic [COUNT-1:1]  onehot
);

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    onehot = '0;
    for (int i = 1; i < COUNT; i++) begin
      onehot[i] = enable && (address == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/mux32to1by32.sv
// Combinational read mux: selects one WIDTH-bit word out of COUNT inputs.
module mux32to1by32
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int COUNT  = REG_COUNT,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  inputs [COUNT],
  output logic [WIDTH-1:0]  out
);

  // COUNT == 2**ADDR_W, so every address value selects a real input.
  assign out = inputs[address];

endmodule

// File: rtl/register32.sv
// Enable-gated storage cell with synchronous active-high clear.
module register32
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrenable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process evaluation order.
  // Clear wins over wrenable so a reset edge never lets a write through.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (wrenable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x 32-bit CPU register file: one synchronous write port, two combinational
// read ports, register 0 hardwired to zero, synchronous active-high reset.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int DEPTH  = REG_COUNT,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2
);

  logic [DEPTH-1:1] wr_en;
  logic [WIDTH-1:0] regs [DEPTH];

  decoder_1to32 #(.COUNT(DEPTH), .ADDR_W(ADDR_W)) u_decoder (
    .enable  (RegWrite),
    .address (WriteRegister),
    .onehot  (wr_en)
  );

  assign regs[ZERO_REG] = '0;

  // NOTE: every storage cell is cleared by reset (not just control state),
  // because reads must return 0 for every register after a reset edge.
  for (genvar i = 1; i < DEPTH; i++) begin : g_cell
    register32 #(.WIDTH(WIDTH)) u_cell (
      .clk      (clk),
      .reset    (reset),
      .wrenable (wr_en[i]),
      .d        (WriteData),
      .q        (regs[i])
    );
  end

  mux32to1by32 #(.WIDTH(WIDTH), .COUNT(DEPTH), .ADDR_W(ADDR_W)) u_mux1 (
    .address (ReadRegister1),
    .inputs  (regs),
    .out     (ReadData1)
  );

  mux32to1by32 #(.WIDTH(WIDTH), .COUNT(DEPTH), .ADDR_W(ADDR_W)) u_mux2 (
    .address (ReadRegister2),
    .inputs  (regs),
    .out     (ReadData2)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed cases with literal expectations,
// then randomized traffic checked every cycle against an array-based model.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteRegister = '0;
  logic [31:0] WriteData = '0;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int vectors     = 0;
  int miscompares = 0;
  bit compare_en  = 1'b0;

  logic [31:0] model [32];

  regfile_2r1w dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Applies one cycle of inputs, advances the model at the edge, and returns
  // just after the following falling edge.
  task automatic drive(input bit rst, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = ra1; ReadRegister2 = ra2;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
    compare_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (compare_en) begin
      check("model_rd1", ReadData1, model[ReadRegister1]);
      check("model_rd2", ReadData2, model[ReadRegister2]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 'x;
    @(negedge clk); #1;

    drive(1, 0, 0, 0, 0, 0);
    check("reset_rd1_r0", ReadData1, 32'h0);

    // Reset wipes a previously written register.
    drive(0, 1, 5, 32'hDEADBEEF, 5, 5);
    check("write_r5", ReadData1, 32'hDEADBEEF);
    drive(1, 0, 0, 0, 5, 5);
    check("reset_r5_rd1", ReadData1, 32'h0);
    check("reset_r5_rd2", ReadData2, 32'h0);

    drive(0, 1, 2, 32'd42, 2, 2);
    check("basic_rd1", ReadData1, 32'd42);
    check("basic_rd2", ReadData2, 32'd42);

    drive(0, 1, 7, 32'd15, 7, 7);
    drive(0, 0, 7, 32'd99, 7, 2);
    check("enable_off_r7", ReadData1, 32'd15);

    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0);
    check("zero_rd1", ReadData1, 32'h0);
    check("zero_rd2", ReadData2, 32'h0);

    for (int i = 1; i < 32; i++) drive(0, 1, 5'(i), 32'(i * 3), 5'(i), 5'(i));
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 5'(i), 32'hA5A5A5A5, 5'(i), 5'(31 - i));
      check("decode_rd1", ReadData1, 32'(i * 3));
      check("decode_rd2", ReadData2, 32'((31 - i) * 3));
    end

    // Read-during-write: old value before the edge, new value after it.
    drive(0, 1, 9, 32'd10, 9, 9);
    reset = 0; RegWrite = 1; WriteRegister = 9; WriteData = 32'd20;
    ReadRegister1 = 9; ReadRegister2 = 9;
    #1;
    check("rdw_before", ReadData1, 32'd10);
    drive(0, 1, 9, 32'd20, 9, 9);
    check("rdw_after", ReadData1, 32'd20);

    drive(0, 1, 3, 32'd55, 3, 3);
    drive(1, 1, 3, 32'd77, 3, 9);
    check("reset_over_write_r3", ReadData1, 32'h0);
    check("reset_over_write_r9", ReadData2, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(63) == 0), $urandom_range(1) == 1,
            5'($urandom_range(31)), $urandom,
            5'($urandom_range(31)), 5'($urandom_range(31)));
    end

    compare_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
